// File: rtl/fetch_seq.sv
// Instruction-fetch sequencer: latches the PC into MAR, reads memory into IR,
// then steps the PC and hands the instruction to execute.
module fetch_seq #(
  parameter int          AW     = 8,
  parameter int          DW     = 8,
  parameter logic [3:0]  HLT_OP = 4'hF
) (
  input  logic          clk,
  input  logic          clr,
  input  logic [AW-1:0] bus_in,
  output logic          pc_oen,
  output logic          pc_inc,
  output logic          load_pc,
  output logic [AW-1:0] mar_out,
  output logic          mem_rd,
  input  logic [DW-1:0] mem_data,
  input  logic          mem_ready,
  output logic [DW-1:0] ir_out,
  output logic          ir_valid,
  input  logic          exec_done,
  input  logic          jump_req,
  output logic          halted,
  output logic [7:0]    instr_count
);

  // One-hot so every strobe is a single state flop.
  typedef enum logic [5:0] {
    T_ADDR = 6'b000001,
    T_READ = 6'b000010,
    T_INC  = 6'b000100,
    T_EXEC = 6'b001000,
    T_JUMP = 6'b010000,
    HALT   = 6'b100000
  } state_e;

  state_e        state_q, state_d;
  logic [AW-1:0] mar_q, mar_d;
  logic [DW-1:0] ir_q, ir_d;
  logic [7:0]    cnt_q, cnt_d;

  always_comb begin
    state_d = state_q;
    mar_d   = mar_q;
    ir_d    = ir_q;
    cnt_d   = cnt_q;
    case (state_q)
      T_ADDR: begin
        mar_d   = bus_in;
        state_d = T_READ;
      end
      T_READ: begin
        if (mem_ready) begin
          ir_d    = mem_data;
          state_d = T_INC;
        end
      end
      T_INC: begin
        cnt_d   = cnt_q + 8'd1;
        state_d = (ir_q[DW-1:DW-4] == HLT_OP) ? HALT : T_EXEC;
      end
      T_EXEC: begin
        if (exec_done)
          state_d = jump_req ? T_JUMP : T_ADDR;
      end
      T_JUMP:  state_d = T_ADDR;
      HALT:    state_d = HALT;
      default: state_d = T_ADDR;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!clr) begin
      state_q <= T_ADDR;
      mar_q   <= '0;
      ir_q    <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      mar_q   <= mar_d;
      ir_q    <= ir_d;
      cnt_q   <= cnt_d;
    end
  end

  // The PC driver stays off the bus while reset is held.
  assign pc_oen      = (state_q == T_ADDR) & clr;
  assign mem_rd      = (state_q == T_READ);
  assign pc_inc      = (state_q == T_INC);
  assign ir_valid    = (state_q == T_EXEC);
  assign load_pc     = (state_q == T_JUMP);
  assign halted      = (state_q == HALT);
  assign mar_out     = mar_q;
  assign ir_out      = ir_q;
  assign instr_count = cnt_q;

endmodule

// File: tb/tb_fetch_seq.sv
// Directed bench for fetch_seq: vector table plus halt, wrap
// and mid-read reset sequences.
module tb_fetch_seq;

  logic       clk;
  logic       clr;
  logic [7:0] bus_in;
  logic       pc_oen, pc_inc, load_pc, mem_rd;
  logic [7:0] mar_out;
  logic [7:0] mem_data;
  logic       mem_ready;
  logic [7:0] ir_out;
  logic       ir_valid;
  logic       exec_done, jump_req;
  logic       halted;
  logic [7:0] instr_count;

  fetch_seq dut (
    .clk        (clk),
    .clr        (clr),
    .bus_in     (bus_in),
    .pc_oen     (pc_oen),
    .pc_inc     (pc_inc),
    .load_pc    (load_pc),
    .mar_out    (mar_out),
    .mem_rd     (mem_rd),
    .mem_data   (mem_data),
    .mem_ready  (mem_ready),
    .ir_out     (ir_out),
    .ir_valid   (ir_valid),
    .exec_done  (exec_done),
    .jump_req   (jump_req),
    .halted     (halted),
    .instr_count(instr_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  localparam logic [5:0] NONE = 6'b000000;
  localparam logic [5:0] OEN  = 6'b100000;
  localparam logic [5:0] INC  = 6'b010000;
  localparam logic [5:0] LD   = 6'b001000;
  localparam logic [5:0] RD   = 6'b000100;
  localparam logic [5:0] VAL  = 6'b000010;
  localparam logic [5:0] HLT  = 6'b000001;

  typedef struct {
    logic       clr;
    logic [7:0] bus;
    logic       rdy;
    logic [7:0] dat;
    logic       done;
    logic       jmp;
    logic [5:0] strb;
    logic [7:0] mar;
    logic [7:0] ir;
    logic [7:0] cnt;
  } vec_t;

  vec_t tv [19];
  int checks;
  int failures;

  function automatic vec_t mk(
    input logic c, input logic [7:0] b, input logic r,
    input logic [7:0] d, input logic dn, input logic j,
    input logic [5:0] s, input logic [7:0] m,
    input logic [7:0] i, input logic [7:0] n);
    vec_t v;
    v.clr = c; v.bus = b; v.rdy = r; v.dat = d;
    v.done = dn; v.jmp = j; v.strb = s;
    v.mar = m; v.ir = i; v.cnt = n;
    return v;
  endfunction

  function automatic logic [5:0] strobes();
    return {pc_oen, pc_inc, load_pc, mem_rd, ir_valid, halted};
  endfunction

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s act=%h exp=%h", nm, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input vec_t v);
    clr       = v.clr;
    bus_in    = v.bus;
    mem_ready = v.rdy;
    mem_data  = v.dat;
    exec_done = v.done;
    jump_req  = v.jmp;
  endtask

  initial begin
    int incs;
    int bad;
    checks   = 0;
    failures = 0;

    tv[0]  = mk(0, 8'hAA, 1, 8'h00, 0, 0, NONE, 8'h00, 8'h00, 8'h00);
    tv[1]  = mk(1, 8'h05, 1, 8'h3C, 0, 0, OEN,  8'h00, 8'h00, 8'h00);
    tv[2]  = mk(1, 8'h00, 1, 8'h3C, 0, 0, RD,   8'h05, 8'h00, 8'h00);
    tv[3]  = mk(1, 8'h00, 0, 8'h00, 0, 0, INC,  8'h05, 8'h3C, 8'h00);
    tv[4]  = mk(1, 8'h00, 0, 8'h00, 0, 0, VAL,  8'h05, 8'h3C, 8'h01);
    tv[5]  = mk(1, 8'h00, 0, 8'h00, 0, 1, VAL,  8'h05, 8'h3C, 8'h01);
    tv[6]  = mk(1, 8'h00, 0, 8'h00, 1, 0, VAL,  8'h05, 8'h3C, 8'h01);
    tv[7]  = mk(1, 8'h10, 1, 8'h77, 0, 0, OEN,  8'h05, 8'h3C, 8'h01);
    tv[8]  = mk(1, 8'h00, 0, 8'h00, 0, 0, RD,   8'h10, 8'h3C, 8'h01);
    tv[9]  = mk(1, 8'h00, 0, 8'h00, 0, 0, RD,   8'h10, 8'h3C, 8'h01);
    tv[10] = mk(1, 8'h00, 0, 8'h00, 0, 0, RD,   8'h10, 8'h3C, 8'h01);
    tv[11] = mk(1, 8'h00, 1, 8'hA5, 0, 0, RD,   8'h10, 8'h3C, 8'h01);
    tv[12] = mk(1, 8'h00, 0, 8'h00, 0, 0, INC,  8'h10, 8'hA5, 8'h01);
    tv[13] = mk(1, 8'h00, 0, 8'h00, 1, 1, VAL,  8'h10, 8'hA5, 8'h02);
    tv[14] = mk(1, 8'h00, 0, 8'h00, 0, 0, LD,   8'h10, 8'hA5, 8'h02);
    tv[15] = mk(1, 8'h20, 0, 8'h00, 0, 0, OEN,  8'h10, 8'hA5, 8'h02);
    tv[16] = mk(1, 8'h00, 1, 8'hF0, 0, 0, RD,   8'h20, 8'hA5, 8'h02);
    tv[17] = mk(1, 8'h00, 0, 8'h00, 0, 0, INC,  8'h20, 8'hF0, 8'h02);
    tv[18] = mk(1, 8'h00, 1, 8'h00, 1, 1, HLT,  8'h20, 8'hF0, 8'h03);

    drive(tv[0]);
    cyc();

    for (int i = 0; i < 19; i++) begin
      drive(tv[i]);
      #1;
      chk($sformatf("v%0d.strb", i), 32'(strobes()), 32'(tv[i].strb));
      chk($sformatf("v%0d.mar", i), 32'(mar_out), 32'(tv[i].mar));
      chk($sformatf("v%0d.ir", i), 32'(ir_out), 32'(tv[i].ir));
      chk($sformatf("v%0d.cnt", i), 32'(instr_count), 32'(tv[i].cnt));
      cyc();
    end

    for (int i = 0; i < 20; i++) begin
      exec_done = 1'($urandom);
      jump_req  = 1'($urandom);
      mem_ready = 1'($urandom);
      bus_in    = 8'($urandom);
      #1;
      chk($sformatf("halt%0d.strb", i), 32'(strobes()), 32'(HLT));
      cyc();
    end

    clr = 1'b0;
    cyc();
    chk("hrst.strb", 32'(strobes()), 32'(NONE));
    chk("hrst.ir", 32'(ir_out), 32'h0);
    chk("hrst.cnt", 32'(instr_count), 32'h0);
    chk("hrst.mar", 32'(mar_out), 32'h0);

    clr = 1'b1; mem_ready = 1'b1; exec_done = 1'b1;
    jump_req = 1'b0; mem_data = 8'h12; bus_in = 8'h00;
    incs = 0;
    bad  = 0;
    for (int i = 0; i < 1024; i++) begin
      if (pc_inc) incs++;
      if (32'(pc_oen) + 32'(pc_inc) + 32'(load_pc) > 1) bad++;
      if (i == 1020)
        chk("wrap.cnt_ff", 32'(instr_count), 32'hFF);
      cyc();
    end
    chk("wrap.incs", incs, 256);
    chk("wrap.cnt", 32'(instr_count), 32'h0);
    chk("wrap.excl", bad, 0);

    bus_in = 8'h33; mem_ready = 1'b0;
    #1;
    chk("mid.addr", 32'(strobes()), 32'(OEN));
    cyc();
    chk("mid.read", 32'(strobes()), 32'(RD));
    chk("mid.mar", 32'(mar_out), 32'h33);
    chk("mid.ir_old", 32'(ir_out), 32'h12);
    clr = 1'b0; mem_ready = 1'b1; mem_data = 8'h55;
    cyc();
    chk("mid.rst_strb", 32'(strobes()), 32'(NONE));
    chk("mid.rst_ir", 32'(ir_out), 32'h0);
    chk("mid.rst_mar", 32'(mar_out), 32'h0);
    chk("mid.rst_cnt", 32'(instr_count), 32'h0);
    clr = 1'b1;
    #1;
    chk("mid.rel_oen", 32'(strobes()), 32'(OEN));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
